fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus data width; only 64 is supported.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 32, instruction entries; a power of two, at least 16.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port entry, input, 64, program entry PC, sampled during reset.
REQ-007 SHALL have port bus_reqcyc, output, 1, bus request valid.
REQ-008 SHALL have port bus_req, output, 64, line-aligned request address.
REQ-009 SHALL have port bus_reqtag, output, BUS_TAG_WIDTH, request tag.
REQ-010 SHALL have port bus_reqack, input, 1, bus accepted the request.
REQ-011 SHALL have port bus_respcyc, input, 1, response beat valid.
REQ-012 SHALL have port bus_resp, input, 64, response beat data.
REQ-013 SHALL have port bus_resptag, input, BUS_TAG_WIDTH, response tag; ignored.
REQ-014 SHALL have port bus_respack, output, 1, beat consumed.
REQ-015 SHALL have port inst_valid, output, 1, head instruction valid to decode.
REQ-016 SHALL have port inst, output, 32, head instruction word.
REQ-017 SHALL have port inst_pc, output, 64, PC of the head instruction.
REQ-018 SHALL have port inst_ready, input, 1, decode accepts the head.
REQ-019 SHALL have port redirect, input, 1, flush and refetch from redirect_pc.
REQ-020 SHALL have port redirect_pc, input, 64, new fetch PC; bits [1:0] are zero.

Function
REQ-021 SHALL use line size 64 bytes = 8 beats = 16 instructions; the request address is fetch_pc with bits [5:0] cleared.
REQ-022 SHALL drive bus_reqtag constantly as SYSBUS_READ<<12 | SYSBUS_MEMORY<<8.
REQ-023 SHALL implement states IDLE, REQ, RECV and DISCARD.
REQ-024 SHALL move from IDLE to REQ when free entries >= 16 and redirect is low.
REQ-025 SHALL, in REQ, hold bus_reqcyc=1 with a stable bus_req until the cycle bus_reqack=1, then go to RECV with beat count 0.
REQ-026 SHALL, in RECV and DISCARD, drive bus_respack = bus_respcyc combinationally; each beat with bus_respcyc=1 increments the beat count.
REQ-027 SHALL, in RECV, enqueue bus_resp[31:0] at line_base+8*beat and then bus_resp[63:32] at line_base+8*beat+4, in that order.
REQ-028 SHALL skip, for the first line after reset or a redirect, instructions whose PC is below fetch_pc (offset fetch_pc[5:2]); they are not enqueued.
REQ-029 SHALL, after the 8th beat, advance fetch_pc to line_base+64 and return to IDLE.
REQ-030 SHALL accept up to 2 enqueues and 1 dequeue per cycle; occupancy = old + enq - deq, never exceeding QUEUE_DEPTH because of the space check in REQ-024.
REQ-031 SHALL drive inst_valid=1 whenever occupancy > 0, with inst and inst_pc showing the head entry; a dequeue occurs when inst_valid and inst_ready are both 1.
REQ-032 SHALL, on redirect=1 in any state, empty the queue and deassert inst_valid next cycle, and set fetch_pc = redirect_pc.
REQ-033 SHALL, on a redirect in IDLE, go to IDLE (or REQ the next cycle per REQ-024).
REQ-034 SHALL, on a redirect in REQ, drop the request only if bus_reqack is low that cycle; otherwise it goes to DISCARD.
REQ-035 SHALL, on a redirect in RECV, go to DISCARD while keeping the beat count.
REQ-036 SHALL, in DISCARD, acknowledge and drop beats until the 8th, then go to IDLE; a further redirect in DISCARD only updates fetch_pc.
REQ-037 SHALL, when a beat and a redirect coincide in RECV, acknowledge the beat and not enqueue it.
REQ-038 SHALL give redirect priority over enqueue and dequeue in the same cycle.
REQ-039 SHALL use wrap-around queue pointers modulo QUEUE_DEPTH.

Reset
REQ-040 SHALL, while reset=1, set state IDLE, fetch_pc=entry, queue empty, beat count 0, and skip offset = entry[5:2].
REQ-041 SHALL hold outputs at reset as bus_reqcyc=0, bus_req=0, bus_respack=0, inst_valid=0, inst=0 and inst_pc=0.
REQ-042 SHALL, on reset mid-transfer, abandon the transfer; the bench does not drive further beats of that transfer.

Verification
REQ-043 Bench SHALL check: entry=0x1000, bus acks after 2 cycles, 8 beats, inst_ready=1 -> one request at 0x1000; 16 instructions with PCs 0x1000..0x103C in order; next request at 0x1040.
REQ-044 Bench SHALL check: entry=0x1014 -> request at 0x1000; first enqueued inst_pc=0x1014; 11 instructions enqueued.
REQ-045 Bench SHALL check: inst_ready=0 throughout -> two lines fetched (32 entries); no third request while full; after one dequeue, still no request until 16 entries are free.
REQ-046 Bench SHALL check: redirect to 0x2008 after beat 3 of a line -> remaining 5 beats acked with no enqueue; inst_valid=0 the next cycle; next request at 0x2000; first inst_pc=0x2008.
REQ-047 Bench SHALL check: redirect in the same cycle as bus_reqack -> DISCARD consumes 8 beats; the queue stays empty until the new line arrives.
REQ-048 Bench SHALL check: reset asserted during RECV -> all outputs at their reset values the next cycle; a new request issues at the line of entry.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with an in-order instruction queue.
//
// Requests whole 64-byte lines from the system bus, splits each 64-bit beat
// into two 32-bit instructions and queues them with their PCs for decode.
// The first line after reset or a redirect drops the instructions that sit
// below the fetch PC inside that line. A redirect flushes the queue at once.
// A transfer that is already accepted by the bus is drained in DISCARD.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   entry           : program entry PC, sampled while reset is high
//   bus_req*        : request channel (valid, line address, tag, accept)
//   bus_resp*       : response channel (beat valid, data, tag, consume)
//   inst_valid/inst/inst_pc/inst_ready : head of queue handshake to decode
//   redirect/redirect_pc               : flush and refetch from a new PC

module fetch_queue #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int QUEUE_DEPTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic [63:0]               inst_pc,
    input  logic                      inst_ready,
    input  logic                      redirect,
    input  logic [63:0]               redirect_pc
);

    localparam int PW            = $clog2(QUEUE_DEPTH);
    localparam int SYSBUS_READ   = 4'b1101;
    localparam int SYSBUS_MEMORY = 4'b0001;
    localparam int TAG_VAL       = (SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DISCARD} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } fq_entry_t;

    state_t          state, state_nxt;
    logic [63:0]     fetch_pc, fetch_pc_nxt;
    logic [2:0]      beat, beat_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count;
    fq_entry_t       mem [QUEUE_DEPTH];
    fq_entry_t       head;

    logic [63:0]     line_base;
    logic [3:0]      skip;
    logic [3:0]      lo_idx, hi_idx;
    logic            beat_fire, last_beat, free_ok;
    logic            enq_lo, enq_hi, deq;
    logic            unused_ok;

    // fetch_pc only carries a non-zero in-line offset for the first line
    // after reset/redirect; every later line starts aligned, so the skip
    // offset falls out of fetch_pc itself.
    assign line_base = {fetch_pc[63:6], 6'b0};
    assign skip      = fetch_pc[5:2];
    assign lo_idx    = {beat, 1'b0};
    assign hi_idx    = {beat, 1'b1};

    assign beat_fire = bus_respcyc && (state == RECV || state == DISCARD);
    assign last_beat = beat_fire && (beat == 3'd7);
    assign free_ok   = ((PW+1)'(QUEUE_DEPTH) - count) >= (PW+1)'(16);

    // A beat that coincides with a redirect is consumed but dropped.
    assign enq_lo = (state == RECV) && bus_respcyc && !redirect && (lo_idx >= skip);
    assign enq_hi = (state == RECV) && bus_respcyc && !redirect && (hi_idx >= skip);
    assign deq    = inst_valid && inst_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= entry;
            beat     <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            beat     <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        beat_nxt     = beat;
        if (beat_fire) beat_nxt = beat + 3'd1;
        case (state)
            IDLE: begin
                if (!redirect && free_ok) state_nxt = REQ;
            end
            REQ: begin
                beat_nxt = '0;
                if (redirect)        state_nxt = bus_reqack ? DISCARD : IDLE;
                else if (bus_reqack) state_nxt = RECV;
            end
            RECV: begin
                // A redirect on the final beat leaves nothing to drain.
                if (last_beat) begin
                    state_nxt = IDLE;
                    if (!redirect) fetch_pc_nxt = line_base + 64'd64;
                end else if (redirect) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect) fetch_pc_nxt = redirect_pc;
    end

    // -------------------------------------------------------------- queue
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq_lo) + PW'(enq_hi);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + (PW+1)'(enq_lo) + (PW+1)'(enq_hi) - (PW+1)'(deq);
        end
    end

    // Low half of a beat is older, so it takes the first free slot.
    always_ff @(posedge clk) begin
        if (enq_lo)
            mem[wr_ptr] <= '{pc: {fetch_pc[63:6], beat, 3'b000}, word: bus_resp[31:0]};
        if (enq_hi)
            mem[enq_lo ? wr_ptr + PW'(1) : wr_ptr] <=
                '{pc: {fetch_pc[63:6], beat, 3'b100}, word: bus_resp[63:32]};
    end

    // ------------------------------------------------------------ outputs
    assign head        = mem[rd_ptr];
    assign inst_valid  = !reset && (count != '0);
    assign inst        = inst_valid ? head.word : '0;
    assign inst_pc     = inst_valid ? head.pc   : '0;

    assign bus_reqcyc  = !reset && (state == REQ);
    assign bus_req     = bus_reqcyc ? line_base : '0;
    assign bus_reqtag  = BUS_TAG_WIDTH'(TAG_VAL);
    assign bus_respack = !reset && beat_fire;

    assign unused_ok   = ^bus_resptag;

endmodule
